// File: rtl/st7789_pkg.sv
// rtl/st7789_pkg.sv - ST7789 opcodes, stream user encoding and arbiter state type
// Shared by the display stream arbiter and its helpers; no ports.
package st7789_pkg;

    // ST7789 command opcodes carried on TUSER=0 beats
    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] INVON   = 8'h21;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] RASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;
    localparam logic [7:0] RAMWRC  = 8'h3C;

    // TUSER bit0: command byte vs parameter/pixel byte
    localparam logic USER_CMD  = 1'b0;
    localparam logic USER_DATA = 1'b1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/st7789_rr_pick.sv
// rtl/st7789_rr_pick.sv - combinational round-robin priority encoder
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot winner), idx (winner index), any (some request present).
module st7789_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; the
    // first one found wins and later candidates are ignored via 'any'.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/st7789_stream_arb.sv
// rtl/st7789_stream_arb.sv - packet-level round-robin arbiter for the ST7789 byte stream
// Ports: CLK/RESET (sync, active-high); S_AXIS_* requester streams, requester i
//        in slice i; S_LOCK keeps the grant past a TLAST; M_AXIS_* to the SPI
//        serializer; GRANT one-hot owner; BUSY high while a grant is held.
module st7789_stream_arb
    import st7789_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [NUM_REQ-1:0]               S_AXIS_TKEEP,
    input  logic [NUM_REQ*USER_WIDTH-1:0]    S_AXIS_TUSER,
    input  logic [NUM_REQ-1:0]               S_AXIS_TVALID,
    input  logic [NUM_REQ-1:0]               S_AXIS_TLAST,
    output logic [NUM_REQ-1:0]               S_AXIS_TREADY,
    input  logic [NUM_REQ-1:0]               S_LOCK,
    output logic [DATA_WIDTH-1:0]            M_AXIS_TDATA,
    output logic                             M_AXIS_TKEEP,
    output logic [USER_WIDTH-1:0]            M_AXIS_TUSER,
    output logic                             M_AXIS_TVALID,
    output logic                             M_AXIS_TLAST,
    input  logic                             M_AXIS_TREADY,
    output logic [NUM_REQ-1:0]               GRANT,
    output logic                             BUSY
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic [IDX_W-1:0]   owner_q, owner_n;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic owner_valid;
    logic owner_last;
    logic owner_lock;

    st7789_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (S_AXIS_TVALID),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // owner_q resets to 0 and only ever holds a picked index, so the data
    // mux always selects a real requester and never produces X.
    assign owner_valid  = S_AXIS_TVALID[owner_q];
    assign owner_last   = S_AXIS_TLAST[owner_q];
    assign owner_lock   = S_LOCK[owner_q];

    assign M_AXIS_TDATA = S_AXIS_TDATA[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign M_AXIS_TUSER = S_AXIS_TUSER[int'(owner_q)*USER_WIDTH +: USER_WIDTH];
    assign M_AXIS_TKEEP = S_AXIS_TKEEP[owner_q];
    assign M_AXIS_TLAST = owner_last;

    assign GRANT = grant_q;
    assign BUSY  = (state_q != ARB_IDLE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_n;
            grant_q  <= grant_n;
            owner_q  <= owner_n;
            rr_ptr_q <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        grant_n       = grant_q;
        owner_n       = owner_q;
        rr_ptr_n      = rr_ptr_q;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = '0;
        case (state_q)
            ARB_IDLE: begin
                // The idle cycle is the arbitration bubble; nothing passes.
                if (pick_any) begin
                    state_n = ARB_XFER;
                    grant_n = pick_grant;
                    owner_n = pick_idx;
                end
            end
            ARB_XFER: begin
                M_AXIS_TVALID          = owner_valid;
                S_AXIS_TREADY[owner_q] = M_AXIS_TREADY;
                // A locked TLAST keeps the owner so the next packet of the
                // sequence follows with no bubble; an owner with TVALID low
                // simply stalls the stream while holding the grant.
                if (owner_valid && M_AXIS_TREADY && owner_last && !owner_lock) begin
                    state_n  = ARB_IDLE;
                    grant_n  = '0;
                    rr_ptr_n = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_st7789_stream_arb.sv
// tb/tb_st7789_stream_arb.sv - randomized self-checking bench for st7789_stream_arb
module tb_st7789_stream_arb;
    import st7789_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int UW = 1;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N*DW-1:0] S_AXIS_TDATA;
    logic [N-1:0]    S_AXIS_TKEEP;
    logic [N*UW-1:0] S_AXIS_TUSER;
    logic [N-1:0]    S_AXIS_TVALID;
    logic [N-1:0]    S_AXIS_TLAST;
    logic [N-1:0]    S_AXIS_TREADY;
    logic [N-1:0]    S_LOCK;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic            M_AXIS_TKEEP;
    logic [UW-1:0]   M_AXIS_TUSER;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [N-1:0]    GRANT;
    logic            BUSY;

    logic [3:0] pk_req;
    logic [1:0] pk_ptr;
    logic [3:0] pk_grant;
    logic [1:0] pk_idx;
    logic       pk_any;

    always #5 CLK = ~CLK;

    st7789_stream_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_LOCK        (S_LOCK),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .GRANT         (GRANT),
        .BUSY          (BUSY)
    );

    st7789_rr_pick #(.NUM_REQ(4), .IDX_W(2)) u_pick (
        .req   (pk_req),
        .ptr   (pk_ptr),
        .grant (pk_grant),
        .idx   (pk_idx),
        .any   (pk_any)
    );

    typedef struct {
        logic [7:0] data;
        logic       user;
        logic       keep;
        logic       last;
        logic       lock;
    } beat_t;

    beat_t      srcq[N][$];
    bit         cur_v[N];
    bit         hs[N];
    int         hs_cnt[N];
    int         own = -1;
    int         ptr = 0;
    int         vpct = 100;
    int         rpct = 100;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] gseq[$];
    logic [3:0] prev_g = 4'h0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic add_beat(int r, logic [7:0] d, logic u, logic k, logic l, logic lk);
        beat_t b;
        b.data = d; b.user = u; b.keep = k; b.last = l; b.lock = lk;
        srcq[r].push_back(b);
    endtask

    task automatic add_rand_pkt(int r, int len, logic lk);
        for (int j = 0; j < len; j++) begin
            add_beat(r, 8'($urandom), (j != 0) ? USER_DATA : USER_CMD, 1'($urandom),
                     (j == len - 1), lk);
        end
    endtask

    // Present queue heads; a presented beat is held until it is accepted.
    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                b = srcq[i].pop_front();
                hs_cnt[i]++;
                cur_v[i] = 1'b0;
                hs[i]    = 1'b0;
            end
            if (!cur_v[i] && srcq[i].size() > 0 && int'($urandom_range(99, 0)) < vpct) begin
                cur_v[i] = 1'b1;
            end
            if (cur_v[i]) begin
                b = srcq[i][0];
                S_AXIS_TDATA[i*DW +: DW] = b.data;
                S_AXIS_TUSER[i*UW +: UW] = b.user;
                S_AXIS_TKEEP[i +: 1]     = b.keep;
                S_AXIS_TLAST[i +: 1]     = b.last;
                S_LOCK[i +: 1]           = b.lock;
                S_AXIS_TVALID[i +: 1]    = 1'b1;
            end else begin
                S_AXIS_TDATA[i*DW +: DW] = 8'($urandom);
                S_AXIS_TUSER[i*UW +: UW] = 1'($urandom);
                S_AXIS_TKEEP[i +: 1]     = 1'($urandom);
                S_AXIS_TLAST[i +: 1]     = 1'($urandom);
                S_LOCK[i +: 1]           = 1'($urandom);
                S_AXIS_TVALID[i +: 1]    = 1'b0;
            end
        end
        M_AXIS_TREADY = int'($urandom_range(99, 0)) < rpct;
    endtask

    // Expected outputs from the reference owner/pointer, compared mid-cycle.
    task automatic observe();
        logic [3:0] eg, esr;
        logic       ebusy, emv;
        beat_t      b;
        eg = 4'h0; esr = 4'h0; ebusy = 1'b0; emv = 1'b0;
        if (own >= 0) begin
            eg    = 4'(1 << own);
            ebusy = 1'b1;
            emv   = cur_v[own];
            if (M_AXIS_TREADY) esr = eg;
            if (emv) begin
                b = srcq[own][0];
                check("tdata", 32'(M_AXIS_TDATA), 32'(b.data));
                check("tuser", 32'(M_AXIS_TUSER), 32'(b.user));
                check("tkeep", 32'(M_AXIS_TKEEP), 32'(b.keep));
                check("tlast", 32'(M_AXIS_TLAST), 32'(b.last));
                if (M_AXIS_TREADY) hs[own] = 1'b1;
            end
        end
        check("grant",  32'(GRANT), 32'(eg));
        check("busy",   32'(BUSY), 32'(ebusy));
        check("mvalid", 32'(M_AXIS_TVALID), 32'(emv));
        check("sready", 32'(S_AXIS_TREADY), 32'(esr));
        check("no_x", 32'($isunknown({M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TKEEP, M_AXIS_TLAST})), 0);
        if (GRANT != 4'h0 && GRANT != prev_g) gseq.push_back(GRANT);
        prev_g = GRANT;
    endtask

    task automatic model_update();
        beat_t b;
        bit    found;
        int    c;
        if (RESET) begin
            own = -1;
            ptr = 0;
        end else if (own < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (!found && cur_v[c]) begin
                    found = 1'b1;
                    own   = c;
                end
            end
        end else if (hs[own]) begin
            b = srcq[own][0];
            if (b.last && !b.lock) begin
                ptr = (own + 1) % N;
                own = -1;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        observe();
        model_update();
        @(posedge CLK);
        #1;
        drive();
    endtask

    function automatic bit done();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) return 1'b0;
        end
        return own < 0;
    endfunction

    task automatic run(int budget, string tag);
        int n;
        n = 0;
        while (!done() && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(done()), 1);
        step();
        step();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        gseq.delete();
    endtask

    // Expected grant order packed one nibble per entry, first in bits [3:0].
    task automatic check_seq(string tag, int n, logic [31:0] packed_exp);
        logic [31:0] w;
        w = packed_exp;
        check({tag, "_len"}, 32'(gseq.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < gseq.size()) check(tag, 32'(gseq[i]), 32'(w[i*4 +: 4]));
        end
    endtask

    initial begin
        logic [7:0] dbl;
        logic [3:0] eg;
        logic [1:0] ei;
        bit         seen;
        int         n;

        RESET         = 1'b1;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        S_LOCK        = '0;
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_v[i] = 1'b0; hs[i] = 1'b0; hs_cnt[i] = 0;
        end

        // Priority encoder alone, every request pattern and pointer.
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 4; p++) begin
                pk_req = 4'(r);
                pk_ptr = 2'(p);
                #1;
                dbl  = {pk_req, pk_req} >> p;
                eg   = 4'h0; ei = 2'd0; seen = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (!seen && dbl[j]) begin
                        seen = 1'b1;
                        ei   = 2'((p + j) % 4);
                        eg   = 4'(1 << ((p + j) % 4));
                    end
                end
                check("pick_any", 32'(pk_any), 32'(seen));
                check("pick_grant", 32'(pk_grant), 32'(eg));
                if (seen) check("pick_idx", 32'(pk_idx), 32'(ei));
            end
        end

        // Single requester; source already valid while reset is held.
        add_beat(0, CASET, USER_CMD, 1'b1, 1'b0, 1'b0);
        add_beat(0, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b0);
        add_beat(0, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b0);
        add_beat(0, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b0);
        add_beat(0, 8'hEF, USER_DATA, 1'b1, 1'b1, 1'b0);
        drive();
        step(); step(); step();
        RESET = 1'b0;
        clear_stats();
        run(50, "s1_drain");
        check_seq("s1_seq", 1, 32'h1);
        check("s1_bytes", 32'(hs_cnt[0]), 5);

        // Contention right after reset: 0, 1, 0.
        do_reset();
        clear_stats();
        add_rand_pkt(0, 3, 1'b0);
        add_rand_pkt(0, 3, 1'b0);
        add_rand_pkt(1, 3, 1'b0);
        run(60, "s2_drain");
        check_seq("s2_seq", 3, 32'h121);

        // Locked CASET/RASET/RAMWR/pixels on req1 with req0 waiting.
        clear_stats();
        add_beat(1, CASET, USER_CMD, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'hEF, USER_DATA, 1'b1, 1'b1, 1'b1);
        add_beat(1, RASET, USER_CMD, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h00, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h01, USER_DATA, 1'b1, 1'b0, 1'b1);
        add_beat(1, 8'h3F, USER_DATA, 1'b1, 1'b1, 1'b1);
        add_beat(1, RAMWR, USER_CMD, 1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            add_beat(1, 8'(8'hA0 + j), USER_DATA, 1'b1, (j == 5), 1'b0);
        end
        add_beat(0, DISPON, USER_CMD, 1'b1, 1'b1, 1'b0);
        run(80, "s3_drain");
        check_seq("s3_seq", 2, 32'h12);
        check("s3_bytes", 32'(hs_cnt[1]), 17);

        // Stalls on both sides with random locks.
        vpct = 50; rpct = 50;
        for (int p = 0; p < 3; p++) add_rand_pkt(0, int'($urandom_range(6, 2)), (p < 2) ? 1'($urandom) : 1'b0);
        for (int p = 0; p < 2; p++) add_rand_pkt(1, int'($urandom_range(6, 2)), (p < 1) ? 1'($urandom) : 1'b0);
        run(600, "s4_drain");

        // Reset in the middle of a 5-byte packet.
        vpct = 100; rpct = 100;
        clear_stats();
        add_rand_pkt(0, 5, 1'b0);
        n = 0;
        while (hs_cnt[0] < 2 && n < 20) begin
            step();
            n++;
        end
        check("s5_two_bytes", 32'(hs_cnt[0] >= 2), 1);
        RESET = 1'b1;
        step();
        step();
        srcq[0].delete();
        cur_v[0] = 1'b0;
        S_AXIS_TVALID[0 +: 1] = 1'b0;
        RESET = 1'b0;
        clear_stats();
        add_rand_pkt(1, 4, 1'b0);
        run(40, "s5_drain");
        check_seq("s5_seq", 1, 32'h2);

        // Four requesters continuously valid.
        do_reset();
        clear_stats();
        for (int r = 0; r < N; r++) begin
            add_rand_pkt(r, int'($urandom_range(4, 1)), 1'b0);
            add_rand_pkt(r, int'($urandom_range(4, 1)), 1'b0);
        end
        run(150, "s6_drain");
        check_seq("s6_seq", 8, 32'h84218421);

        // Random soak, final packet of each requester unlocked.
        vpct = 50; rpct = 70;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 8; p++) begin
                add_rand_pkt(r, int'($urandom_range(5, 1)), (p < 7) ? 1'($urandom) : 1'b0);
            end
        end
        run(5000, "s7_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/st7789_stream_arb.md
Name: st7789_stream_arb

Overview:
- Packet-level arbiter that shares the single ST7789 command/pixel byte stream between NUM_REQ AXI-Stream requesters, e.g. the init/fill manager and an overlay renderer.
- Sits between the requesters' output FIFOs and the SPI serializer.
- Stream convention: TUSER=0 marks a command byte, TUSER=1 a parameter/pixel byte, TLAST ends a command transaction.
- Grants whole packets round-robin. A LOCK sideband keeps multi-packet sequences (CASET, RASET, RAMWR, pixels) atomic.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, byte lane width.
- USER_WIDTH, 1, TUSER width (bit0 = data/command flag).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset: RESET, synchronous, active-high; clock CLK.
- S_AXIS_TDATA  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i occupies slice i.
- S_AXIS_TKEEP  in  NUM_REQ  per-requester keep.
- S_AXIS_TUSER  in  NUM_REQ*USER_WIDTH  per-requester user.
- S_AXIS_TVALID  in  NUM_REQ  per-requester valid.
- S_AXIS_TLAST  in  NUM_REQ  per-requester last.
- S_AXIS_TREADY  out  NUM_REQ  per-requester ready.
- S_LOCK  in  NUM_REQ  sampled on the TLAST beat; 1 = keep the grant for the next packet.
- M_AXIS_TDATA  out  DATA_WIDTH  to serializer.
- M_AXIS_TKEEP  out  1  to serializer.
- M_AXIS_TUSER  out  USER_WIDTH  to serializer.
- M_AXIS_TVALID  out  1  to serializer.
- M_AXIS_TLAST  out  1  to serializer.
- M_AXIS_TREADY  in  1  from serializer.
- GRANT  out  NUM_REQ  one-hot current owner; all zero when idle.
- BUSY  out  1  high in any state other than ARB_IDLE.

Behaviour:
- Reset values: state ARB_IDLE, GRANT=0, BUSY=0, M_AXIS_TVALID=0, all S_AXIS_TREADY=0, rr pointer=0, lock flag=0.
- M_AXIS_TDATA/TUSER/TKEEP/TLAST are don't-care while TVALID=0 and must not be X.
- ARB_IDLE:
  - If any S_AXIS_TVALID is high, pick the winner with rr_pick starting at the rr pointer.
  - Register GRANT one-hot and go to ARB_XFER.
  - Arbitration bubble is exactly 1 cycle: no beat transfers during the idle cycle.
- ARB_XFER, owner g:
  - M_AXIS_* is combinationally muxed from requester g.
  - S_AXIS_TREADY[g] = M_AXIS_TREADY; all other TREADY bits are 0.
  - Data path latency is zero cycles.
  - Owner TVALID dropping mid-packet: grant is held and no other requester is served. Packets are never interleaved.
- Handshake with TLAST=1 on owner g:
  - S_LOCK[g]=1: stay in ARB_XFER with the same owner. The next packet may start the following cycle with no bubble.
  - S_LOCK[g]=0: rr pointer <= (g+1) mod NUM_REQ, GRANT <= 0, go to ARB_IDLE.
- Lock release: a locked owner that finishes with LOCK=0 releases normally. A locked owner never loses the grant to another requester.
- Simultaneous requests: the first valid requester at or after the rr pointer wins, wrapping modulo NUM_REQ.
- Fairness: with all requesters continuously valid and unlocked, grants rotate 0,1,…,NUM_REQ-1,0.
- Non-owner requesters may assert TVALID at any time. Their TREADY stays 0, and their data must remain stable per AXI-S rules (not checked here).
- RESET mid-packet: the grant drops on the next edge, and the serializer sees a truncated packet with no TLAST. The system restarts the display via software reset (0x01), so no recovery is required in this block.
- TREADY low with TVALID high: hold state; the beat is counted only on TVALID&&TREADY.
- Only the first bit of each S_LOCK element is meaningful. No width arithmetic; mux indices are $clog2(NUM_REQ) bits.

Decomposition:
- Package st7789_pkg:
  - ST7789 opcode localparams: SWRESET 8'h01, SLPOUT 8'h11, INVON 8'h21, DISPON 8'h29, CASET 8'h2A, RASET 8'h2B, RAMWR 8'h2C, RAMWRC 8'h3C.
  - TUSER encoding constants: USER_CMD=0, USER_DATA=1.
  - Arbiter state typedef {ARB_IDLE, ARB_XFER}.
- One sub-module, st7789_rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Unit-tested separately.

Test Plan:
- Single requester: req0 sends {2A u0}, {00,00,00,EF u1 last}; M_AXIS_TREADY=1. Expect 5 bytes out in order, GRANT=01, ARB_IDLE one cycle after TLAST.
- Contention: both valid at the same cycle after reset, each with 3-byte packets. Expect req0 packet then req1 packet, then req0 again with one bubble between each, with no interleaving.
- Lock: req1 holds S_LOCK=1 across CASET, RASET, RAMWR and then 6 pixel bytes, with its LOCK=0 on the final packet; req0 is valid throughout. Expect all req1 packets back-to-back with no bubble; req0 is granted only after the final req1 TLAST.
- Stall: during req0's packet, toggle M_AXIS_TREADY 1,0,0,1 and drop req0 TVALID for 2 cycles mid-packet. Expect no byte loss or duplication, and the grant held on req0 while req1 is pending.
- Reset mid-packet: assert RESET after byte 2 of 5. Expect GRANT=0, TVALID=0, TREADY=0 the next cycle. After release, req1 wins first if only req1 is valid.
- NUM_REQ=4 with all requesters continuously valid: expect grant order 0,1,2,3,0 over 5 packets.
